// File: rtl/skid_pipe_reg.sv
// skid_pipe_reg
// Elastic pipeline register with valid/ready handshakes on both sides.
// A one-entry skid buffer absorbs downstream backpressure. This keeps
// in_ready a function of the local state and flush only, so there is no
// combinational path from out_ready to in_ready. A synchronous flush
// squashes every held word, for example on a branch or jump redirect.
//
// Optional feature: define SKID_PIPE_REG_STALL_CNT_EN to add a 16-bit
// saturating stall counter output (stall_cnt). Reset clears it; flush
// does not.
//
// Ports:
//   clk        single clock, rising-edge
//   rst        asynchronous reset, active-low
//   flush      synchronous squash of all held words
//   in_valid   upstream word present on in_data
//   in_ready   block can accept a word this cycle
//   in_data    upstream data word [n-1:0]
//   out_valid  out_data holds a valid word
//   out_ready  downstream accepts the word this cycle
//   stall_cnt  (optional) cycles with out_valid=1 and out_ready=0
//   out_data   downstream data word [n-1:0], always the main register
module skid_pipe_reg #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef SKID_PIPE_REG_STALL_CNT_EN
  output logic [15:0]  stall_cnt,
`endif
  output logic [n-1:0] out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [n-1:0] main_data;
  logic [n-1:0] main_next;
  logic [n-1:0] skid_data;
  logic [n-1:0] skid_next;
  logic         in_fire;
  logic         out_fire;

  // State and data registers. Reset returns everything to zero so the
  // output reads as an idle, zeroed word immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_next;
      main_data <= main_next;
      skid_data <= skid_next;
    end
  end

  // Next-state logic and handshake outputs. Flush takes priority over
  // everything. A downstream accept in the flush cycle is still a legal
  // consume, and nothing is accepted from upstream in that cycle.
  always_comb begin
    state_next = state;
    main_next  = main_data;
    skid_next  = skid_data;
    in_ready   = (state != FULL) && !flush;
    out_valid  = (state != EMPTY);
    out_data   = main_data;
    in_fire    = in_valid && in_ready;
    out_fire   = out_valid && out_ready;

    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_next  = in_data;
            state_next = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_next = in_data;
          end else if (in_fire) begin
            // Downstream stalled, so park the new word behind main.
            skid_next  = in_data;
            state_next = FULL;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_next  = skid_data;
            state_next = BUSY;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

`ifdef SKID_PIPE_REG_STALL_CNT_EN
  // Counts cycles in which a valid word sits unconsumed. The count
  // saturates rather than wraps, and only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_skid_pipe_reg.sv
// tb_skid_pipe_reg
// Directed bench for skid_pipe_reg. A queue-based reference model tracks
// the words that have been accepted and not yet consumed (at most two).
// A compare process checks the DUT against that model on every falling
// edge. Directed steps add hand-computed literal expectations.
module tb_skid_pipe_reg;

  localparam int N = 32;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
`ifdef SKID_PIPE_REG_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  int tests_run;
  int tests_failed;

  logic [N-1:0] model_q[$];
  int           model_stall;

  skid_pipe_reg #(.n(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SKID_PIPE_REG_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .out_data  (out_data)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records one comparison, and prints a FAIL line when it does not match.
  task automatic checkOutput(input string name, input logic [N-1:0] actual,
                             input logic [N-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs just after a rising edge, then returns just
  // after the following falling edge, when the outputs are settled.
  task automatic applyStimulus(input logic v, input logic [N-1:0] d,
                               input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
  endtask

  // Reference model: a FIFO of accepted words with room for two. Flush
  // empties it. Otherwise the head leaves on a downstream accept and a new
  // word joins the tail on an upstream accept.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_q.delete();
      model_stall = 0;
    end else begin
      automatic bit can_take = (model_q.size() < 2) && !flush;
      automatic bit take     = in_valid && can_take;
      automatic bit give     = (model_q.size() > 0) && out_ready;
      if ((model_q.size() > 0) && !out_ready && (model_stall < 65535))
        model_stall++;
      if (flush) begin
        model_q.delete();
      end else begin
        if (give) void'(model_q.pop_front());
        if (take) model_q.push_back(in_data);
      end
    end
  end

  // Compares the DUT against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("in_ready",  {31'd0, in_ready},
                  {31'd0, (model_q.size() < 2) && !flush});
      checkOutput("out_valid", {31'd0, out_valid},
                  {31'd0, model_q.size() > 0});
      if (model_q.size() > 0)
        checkOutput("out_data", out_data, model_q[0]);
`ifdef SKID_PIPE_REG_STALL_CNT_EN
      checkOutput("stall_cnt", {16'd0, stall_cnt}, model_stall[N-1:0]);
`endif
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Hold reset for three cycles, then release it.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Stream 1..4 at full throughput.
    applyStimulus(1'b1, 32'd1, 1'b1, 1'b0);
    checkOutput("stream in_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b1, 32'd2, 1'b1, 1'b0);
    checkOutput("stream data1", out_data, 32'd1);
    checkOutput("stream in_ready2", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b1, 32'd3, 1'b1, 1'b0);
    checkOutput("stream data2", out_data, 32'd2);
    applyStimulus(1'b1, 32'd4, 1'b1, 1'b0);
    checkOutput("stream data3", out_data, 32'd3);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("stream data4", out_data, 32'd4);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("stream drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: A and B fill main and skid, then C is refused.
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
    checkOutput("bp hold A", out_data, 32'hA);
    checkOutput("bp ready busy", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);
    checkOutput("bp full ready", {31'd0, in_ready}, 32'd0);
    checkOutput("bp full data", out_data, 32'hA);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);
    checkOutput("bp stable data", out_data, 32'hA);
    applyStimulus(1'b1, 32'hC, 1'b1, 1'b0);
    checkOutput("bp consume A", out_data, 32'hA);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);
    checkOutput("bp B in main", out_data, 32'hB);
    checkOutput("bp ready again", {31'd0, in_ready}, 32'd1);

    // Flush while full (B, C held) with D offered: D is refused.
    applyStimulus(1'b1, 32'hD, 1'b0, 1'b1);
    checkOutput("flush in_ready", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("flush out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush in_ready after", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("flush D absent", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in BUSY, asserted between clock edges.
    applyStimulus(1'b1, 32'h5, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("busy data", out_data, 32'h5);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async out_data", out_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

`ifdef SKID_PIPE_REG_STALL_CNT_EN
    // Ten stalled cycles, then a flush out of BUSY, then reset.
    applyStimulus(1'b1, 32'h7, 1'b0, 1'b0);
    repeat (10) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    checkOutput("stall ten", {16'd0, stall_cnt}, 32'd10);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("stall after flush", {16'd0, stall_cnt}, 32'd10);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("stall reset", {16'd0, stall_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
`endif

    // Short final stream to check that operation resumes after reset.
    applyStimulus(1'b1, 32'h11, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b0, 1'b0);
    checkOutput("resume data", out_data, 32'h11);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("resume hold", out_data, 32'h11);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("resume next", out_data, 32'h22);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/skid_pipe_reg.md
Name: skid_pipe_reg

Overview:
Elastic pipeline register for the pipelined RISC-V datapath, with valid/ready handshakes on both sides. The plain loaded register only captures data when an upstream load is asserted. This block adds the consumer end of that interface: it accepts a word from the upstream stage and holds it until the downstream stage takes it, absorbing backpressure with a one-entry skid buffer. The upstream stage can therefore run at full throughput with no combinational path from out_ready to in_ready. The stage controller drives flush to squash in-flight words on a branch or jump redirect.

Parameters:
n, 32, data word width in bits

Ports:
clk  input  1  single clock, all state updates on the rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
flush  input  1  synchronous squash of all held words
in_valid  input  1  upstream word present on in_data
in_ready  output  1  block can accept a word this cycle
in_data  input  n  upstream data word
out_valid  output  1  out_data holds a valid word
out_ready  input  1  downstream accepts the word this cycle
out_data  output  n  downstream data word, always driven from the main register

Behaviour:
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (main_data, main_valid) and skid register (skid_data, skid_valid).
- States:
  - EMPTY: main_valid=0, skid_valid=0.
  - BUSY: main_valid=1, skid_valid=0.
  - FULL: main_valid=1, skid_valid=1.
- Outputs:
  - out_valid = main_valid; out_data = main_data.
  - in_ready = (state != FULL) & ~flush. in_ready depends only on state and flush, never on out_ready.
- Reset (rst=0, asynchronous): state=EMPTY, both data registers=0, out_valid=0, out_data=0.
  - in_ready reads 1 from the first clock edge after rst rises, provided flush=0.
  - Reset in mid-transfer discards all held words with no partial output.
- Transitions on the rising clock edge, in priority order:
  - flush=1: go to EMPTY. Any input offered that cycle is not accepted (in_ready=0). Any downstream accept that cycle is still a legal consume. Data register contents are don't-care.
  - EMPTY: in_fire -> main<=in_data, go to BUSY. Latency from accept to out_valid is 1 cycle.
  - BUSY:
    - in_fire & out_fire -> main<=in_data, stay in BUSY (full throughput, one word per cycle).
    - in_fire & ~out_fire -> skid<=in_data, go to FULL.
    - ~in_fire & out_fire -> go to EMPTY.
    - Neither -> hold.
  - FULL: in_ready=0.
    - out_fire -> main<=skid, clear skid, go to BUSY.
    - Otherwise hold.
- Ordering: words leave in the order they were accepted. No word is dropped or duplicated except by flush.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid stay stable.
- Upstream protocol violations (in_data changing while in_valid=1 & in_ready=0) are not checked.

Optional Feature:
Macro SKID_PIPE_REG_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [15:0].
  - Increments every cycle with out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared only by reset, not by flush.
- Undefined: the port and its counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then stream: rst=0 for 3 cycles, then release; assert in_valid with data 1,2,3,4 on consecutive cycles, out_ready=1 throughout -> in_ready=1 every cycle; out_data=1,2,3,4 on consecutive cycles starting 1 cycle after the first accept.
- Backpressure: with out_ready=0, push 0xA then 0xB -> both accepted, state=FULL, in_ready=0, out_data holds 0xA. Then out_ready=1 for 2 cycles -> out_data=0xA, then 0xB, then out_valid=0.
- Simultaneous events in FULL: hold out_ready=0 and in_valid=1 with 0xC pending -> 0xC is not accepted. Then out_ready=1 -> 0xA leaves, 0xB moves to main, in_ready=1 on the next cycle, 0xC accepted into skid. Output order is 0xA, 0xB, 0xC.
- Flush: in FULL state, pulse flush=1 with in_valid=1 and data 0xD -> in_ready=0 that cycle; next cycle out_valid=0, in_ready=1; 0xD never appears on out_data.
- Async reset mid-operation: in BUSY, drop rst between clock edges -> out_valid and out_data go to 0 immediately, before the next edge.
- With SKID_PIPE_REG_STALL_CNT_EN defined: hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=10; a flush leaves stall_cnt=10; reset clears it to 0.
